// File: rtl/ram_port_master.sv
// Request/response front end for a 1-cycle-latency SRAM. Reads return data at t+2 at the earliest, through a 2-entry FIFO.
// Credits (FIFO count plus read in flight) hold off req_rdy. A pop in the same cycle frees a credit for that cycle's request.

module ram_port_fifo #(
  parameter int W  = 64,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          vld,
  output logic [W-1:0]  dat,
  output logic [PW:0]   cnt
);
  localparam int DEPTH = 1 << PW;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign vld = (cnt != '0);
  assign dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; count and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst) push |-> (cnt != FULL));

endmodule

module ram_port_master #(
  parameter  int P_DW = 6,
  parameter  int AW   = 6,
  localparam int DW   = 1 << P_DW,
  localparam int BW   = DW / 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [BW-1:0] req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdat,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_rdat,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic [BW-1:0] ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  logic       inflight;
  logic [1:0] count;
  logic [1:0] occupancy;
  logic       pop;
  logic       accept;

  assign pop       = rsp_vld & rsp_rdy;
  assign occupancy = count + {1'b0, inflight};
  // rsp_rdy feeds req_rdy combinationally so a full FIFO still streams.
  assign req_rdy   = (occupancy < 2'd2) | pop;
  assign accept    = req_vld & req_rdy;

  assign ram_addr  = req_addr;
  assign ram_din   = req_wdat;
  assign ram_re    = accept & (req_we == '0);
  assign ram_we    = accept ? req_we : '0;

  // ram_dout is only trusted in the cycle right after RE; post-write output is undefined.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) inflight <= 1'b0;
    else     inflight <= ram_re;
  end

  ram_port_fifo #(.W(DW), .PW(1)) u_rsp_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (inflight),
    .push_dat (ram_dout),
    .pop      (pop),
    .vld      (rsp_vld),
    .dat      (rsp_rdat),
    .cnt      (count)
  );

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural 1-cycle SRAM that outputs garbage after writes.

module tb_ram_port_master;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [7:0]  req_we = '0;
  logic [5:0]  req_addr = '0;
  logic [63:0] req_wdat = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [63:0] rsp_rdat;
  logic [5:0]  ram_addr;
  logic        ram_re;
  logic [7:0]  ram_we;
  logic [63:0] ram_din;
  logic [63:0] ram_dout = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sram [64];

  ram_port_master #(.P_DW(6), .AW(6)) dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdat(req_wdat),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdat(rsp_rdat),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_re) begin
      ram_dout <= sram[ram_addr];
    end else if (ram_we != '0) begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) sram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      ram_dout <= {$urandom, $urandom};
    end
  end

  function automatic logic [63:0] init_val(input int a);
    logic [7:0] v;
    v = a[7:0];
    return {8{v}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] we, input logic [5:0] addr,
                       input logic [63:0] wdat, input logic rdy);
    @(negedge CLK);
    req_vld  = vld;
    req_we   = we;
    req_addr = addr;
    req_wdat = wdat;
    rsp_rdy  = rdy;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = init_val(i);

    // Reset values, then async reset mid-operation
    #12;
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_req_rdy", req_rdy, 1);
    @(negedge CLK);
    RST = 1'b0;
    drive(1, 8'h00, 6'd1, 0, 0);
    drive(1, 8'h00, 6'd2, 0, 0);
    drive(0, 8'h00, 6'd0, 0, 0);
    chk("pre_rst_req_rdy", req_rdy, 0);
    chk("pre_rst_rsp_vld", rsp_vld, 1);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_rsp_vld", rsp_vld, 0);
    chk("async_rst_req_rdy", req_rdy, 1);
    chk("async_rst_ram_re", ram_re, 0);
    chk("async_rst_ram_we", ram_we, 0);
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 8'h00, 6'd0, 0, 1);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("post_rst_rsp_vld", rsp_vld, 0);

    // Back-to-back reads 0..7 with rsp_rdy held high
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h00, 6'(i), 0, 1);
      chk("b2b_req_rdy", req_rdy, 1);
      chk("b2b_ram_re", ram_re, 1);
      if (i >= 2) begin
        chk("b2b_rsp_vld", rsp_vld, 1);
        chk("b2b_rsp_rdat", rsp_rdat, init_val(i - 2));
      end
    end
    for (int i = 6; i < 8; i++) begin
      drive(0, 8'h00, 6'd0, 0, 1);
      chk("b2b_tail_vld", rsp_vld, 1);
      chk("b2b_tail_rdat", rsp_rdat, init_val(i));
    end
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("b2b_drained", rsp_vld, 0);

    // Write then read addr 5
    drive(1, 8'hFF, 6'd5, 64'h1122334455667788, 1);
    chk("wr_req_rdy", req_rdy, 1);
    chk("wr_ram_we", ram_we, 8'hFF);
    chk("wr_ram_re", ram_re, 0);
    chk("wr_ram_addr", ram_addr, 5);
    chk("wr_ram_din", ram_din, 64'h1122334455667788);
    drive(1, 8'h00, 6'd5, 0, 1);
    chk("rd_ram_re", ram_re, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, 5);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rd_lat_t1_vld", rsp_vld, 0);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rd_lat_t2_vld", rsp_vld, 1);
    chk("rd_lat_t2_rdat", rsp_rdat, 64'h1122334455667788);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rd_single_rsp", rsp_vld, 0);

    // Byte mask: lanes 0-3 overwritten
    drive(1, 8'hFF, 6'd3, 64'h5555555555555555, 1);
    drive(1, 8'h0F, 6'd3, 64'hAAAAAAAAAAAAAAAA, 1);
    drive(1, 8'h00, 6'd3, 0, 1);
    drive(0, 8'h00, 6'd0, 0, 1);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("mask_vld", rsp_vld, 1);
    chk("mask_rdat", rsp_rdat, 64'h55555555AAAAAAAA);

    // Backpressure: 3 reads with rsp_rdy low
    drive(1, 8'h00, 6'd5, 0, 0);
    chk("bp_acc0", req_rdy, 1);
    drive(1, 8'h00, 6'd3, 0, 0);
    chk("bp_acc1", req_rdy, 1);
    drive(1, 8'h00, 6'd6, 0, 0);
    chk("bp_block_rdy", req_rdy, 0);
    chk("bp_block_re", ram_re, 0);
    chk("bp_head_vld", rsp_vld, 1);
    chk("bp_head_rdat", rsp_rdat, 64'h1122334455667788);
    drive(1, 8'h00, 6'd6, 0, 0);
    chk("bp_full_rdy", req_rdy, 0);
    chk("bp_stable_rdat", rsp_rdat, 64'h1122334455667788);
    drive(1, 8'h00, 6'd6, 0, 1);
    chk("bp_pop_rdy", req_rdy, 1);
    chk("bp_pop_re", ram_re, 1);
    chk("bp_pop0_rdat", rsp_rdat, 64'h1122334455667788);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("bp_pop1_vld", rsp_vld, 1);
    chk("bp_pop1_rdat", rsp_rdat, 64'h55555555AAAAAAAA);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("bp_pop2_vld", rsp_vld, 1);
    chk("bp_pop2_rdat", rsp_rdat, init_val(6));
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("bp_drained", rsp_vld, 0);

    // Read then write to same address on consecutive cycles
    drive(1, 8'h00, 6'd6, 0, 1);
    chk("rw_ram_re", ram_re, 1);
    drive(1, 8'hFF, 6'd6, 64'hDEADBEEFCAFEF00D, 1);
    chk("rw_wr_rdy", req_rdy, 1);
    chk("rw_ram_we", ram_we, 8'hFF);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rw_old_vld", rsp_vld, 1);
    chk("rw_old_rdat", rsp_rdat, init_val(6));
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rw_no_extra", rsp_vld, 0);
    drive(1, 8'h00, 6'd6, 0, 1);
    drive(0, 8'h00, 6'd0, 0, 1);
    drive(0, 8'h00, 6'd0, 0, 1);
    chk("rw_new_vld", rsp_vld, 1);
    chk("rw_new_rdat", rsp_rdat, 64'hDEADBEEFCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_port_master.md
# ram_port_master

Request-side controller for the byte-enabled single-port SRAM macro wrapper (`mRAM_s_s_be` port set: ADDR/RE/WE/DIN/DOUT). It converts a valid/ready request stream (reads and byte-masked writes) into SRAM port cycles. It captures read data in the single cycle it is valid, then returns it in order on a valid/ready response stream through a 2-entry response FIFO. It sits between cache/TCM control logic and any SRAM instance, and hides the SRAM's fixed 1-cycle read latency and its inability to stall.

## Interface
Parameters:
- P_DW, 6, log2 of data width in bits; DW = 1<<P_DW, byte lanes BW = DW/8.
- AW, 6, address width in words.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_we  in  BW  byte write mask; 0 = read, non-zero = write.
- req_addr  in  AW  word address.
- req_wdat  in  DW  write data.
- rsp_vld  out  1  read response valid.
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy.
- rsp_rdat  out  DW  read data.
- ram_addr  out  AW  to SRAM ADDR.
- ram_re  out  1  to SRAM RE.
- ram_we  out  BW  to SRAM WE.
- ram_din  out  DW  to SRAM DIN.
- ram_dout  in  DW  from SRAM DOUT.

## Operation
- Accepted read (cycle t): ram_re=1, ram_we=0, ram_addr=req_addr, all combinational in cycle t. The in-flight flag is set at end of t.
- Accepted write (cycle t): ram_we=req_we, ram_din=req_wdat, ram_addr=req_addr, ram_re=0 in cycle t. No response is generated.
- No acceptance: ram_re=0 and ram_we=0. ram_addr and ram_din are don't-care.
- At most one request per cycle, so RE and WE are never both active.
- Capture: when the in-flight flag is set in cycle t+1, ram_dout is pushed into the FIFO at end of t+1. It is sampled exactly once, because the SRAM output is undefined in the cycle after a write.
- Response FIFO: 2 entries, 1-bit write/read pointers, 2-bit count. rsp_vld = (count!=0). rsp_rdat = entry at read pointer.
- Credit: occupancy = count + inflight (0..2).
- req_rdy = (occupancy < 2) | (rsp_vld & rsp_rdy). The combinational path from rsp_rdy to req_rdy is intentional.
- req_rdy is independent of req_we, so writes are also held off when credits are exhausted. This keeps ordering simple.
- Ordering: responses are returned in request order. A read after a write to the same address returns the written bytes. Unwritten byte lanes keep their prior value.
- Simultaneous push and pop: count unchanged, both pointers advance.
- A push can never occur while count==2. The credit rule guarantees this; a push at count==2 is a bug, flagged by a simulation assertion.

## Timing
- Reset values (asynchronous, while RST=1): inflight=0, count=0, pointers=0. This gives rsp_vld=0, req_rdy=1, ram_re=0, ram_we=0.
- RST mid-operation discards in-flight reads and buffered responses. SRAM contents are untouched.
- Read latency: accept in cycle t gives rsp_vld=1 in t+2 (earliest).
- Throughput with rsp_rdy held 1: one read per cycle sustained, no bubbles. Writes are also one per cycle.
- With rsp_rdy=0: at most 2 reads accepted, then req_rdy=0 until a pop. A pop cycle may accept a new request.
- rsp_rdat is stable while rsp_vld & ~rsp_rdy.

## Test plan
- Reset: assert RST asynchronously mid-cycle → rsp_vld=0, req_rdy=1, ram_re=0, ram_we=0 immediately. Run with P_DW=6, AW=6.
- Write then read: write addr 5, data 0x1122334455667788, we=0xFF. Then read addr 5 → ram_re=1 with ram_addr=5 in the accept cycle, and rsp_rdat=0x1122334455667788 two cycles later.
- Byte mask: write 0xAAAA… to addr 3 with we=0x0F after 0x5555… → read returns 0x55555555AAAAAAAA.
- Back-to-back reads of addr 0..7 with rsp_rdy=1 → req_rdy stays 1 for all 8 accepts, 8 responses in order on consecutive cycles.
- Backpressure: rsp_rdy=0, issue 3 reads → only 2 accepted, req_rdy=0 while occupancy=2. Raise rsp_rdy → the third read is accepted in the same cycle as the first pop, and order is preserved.
- Read then write back-to-back to the same address (cycle t read, t+1 write) → the response carries the old data, with no corruption from the SRAM's post-write uncertain output.
